// File: rtl/spi_pixel_loader_if.sv
// rtl/spi_pixel_loader_if.sv - byte-in / frame-memory-out bundle for spi_pixel_loader
interface spi_pixel_loader_if #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 8
);
    logic [DATA_BITS-1:0] byteData;
    logic                 byteValid;
    logic                 frameAck;
    logic                 memWe;
    logic [ADDR_BITS-1:0] memAddr;
    logic [DATA_BITS-1:0] memData;
    logic                 frameReady;
    logic                 overrunErr;

    // Byte source and frame consumer side
    modport master (
        output byteData, byteValid, frameAck,
        input  memWe, memAddr, memData, frameReady, overrunErr
    );

    // Loader side
    modport slave (
        input  byteData, byteValid, frameAck,
        output memWe, memAddr, memData, frameReady, overrunErr
    );
endinterface

// File: rtl/spi_pixel_loader.sv
// rtl/spi_pixel_loader.sv - frames a synchronised SPI byte stream into raster frame-memory writes
module spi_pixel_loader #(
    parameter int                   DATA_BITS  = 8,
    parameter int                   IMG_WIDTH  = 16,
    parameter int                   IMG_HEIGHT = 16,
    parameter logic [DATA_BITS-1:0] SYNC_BYTE  = DATA_BITS'(8'hA5)
) (
    input  logic              clk,
    input  logic              nRst,
    spi_pixel_loader_if.slave bus
);
    localparam int ADDR_BITS = $clog2(IMG_WIDTH * IMG_HEIGHT);
    localparam int COL_W     = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_v1, r_v2, r_v3;
    logic                 w_byte_evt;
    logic [COL_W-1:0]     r_col, w_col_nxt;
    logic [ROW_W-1:0]     r_row, w_row_nxt;
    logic                 r_we, w_we_nxt;
    logic [ADDR_BITS-1:0] r_addr, w_addr_nxt, w_addr;
    logic [DATA_BITS-1:0] r_data, w_data_nxt;
    logic                 r_ready, w_ready_nxt;
    logic                 r_ovr, w_ovr_nxt;

    // Bring the level-held byteValid into clk domain and keep one extra stage for edge detection
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            r_v1 <= bus.byteValid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    // One event per byte: byteData is already quasi-static when the synchronised rise is seen
    assign w_byte_evt = r_v2 & ~r_v3;
    assign w_addr     = ADDR_BITS'(int'(r_row) * IMG_WIDTH + int'(r_col));

    // State, raster position and registered memory-port outputs
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_ready <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_ready <= w_ready_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    // Next-state logic: sync hunt, raster fill, then hold the frame until the core acknowledges
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_ready_nxt = r_ready;
        w_ovr_nxt   = r_ovr;
        case (r_state)
            IDLE: begin
                if (w_byte_evt && (bus.byteData == SYNC_BYTE)) begin
                    w_state_nxt = LOAD;
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                end
            end
            LOAD: begin
                // Sync value here is ordinary pixel data
                if (w_byte_evt) begin
                    w_we_nxt   = 1'b1;
                    w_addr_nxt = w_addr;
                    w_data_nxt = bus.byteData;
                    if (r_col == COL_W'(IMG_WIDTH - 1)) begin
                        w_col_nxt = '0;
                        if (r_row == ROW_W'(IMG_HEIGHT - 1)) begin
                            w_row_nxt   = '0;
                            w_ready_nxt = 1'b1;
                            w_state_nxt = READY;
                        end else begin
                            w_row_nxt = r_row + 1'b1;
                        end
                    end else begin
                        w_col_nxt = r_col + 1'b1;
                    end
                end
            end
            READY: begin
                // Ack takes priority; a coincident byte is dropped without being sync-checked
                if (bus.frameAck) begin
                    w_ready_nxt = 1'b0;
                    w_ovr_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end else if (w_byte_evt) begin
                    w_ovr_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.memWe      = r_we;
    assign bus.memAddr    = r_addr;
    assign bus.memData    = r_data;
    assign bus.frameReady = r_ready;
    assign bus.overrunErr = r_ovr;
endmodule
